// File: rtl/floating_point_softmax_input_collector_if.sv
// Handshake and result bus between an upstream word source, the softmax
// input collector and the downstream softmax engine.
// The collector uses the slave modport; the driving side uses master.
interface floating_point_softmax_input_collector_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  flush;
    logic                  softmax_done;
    logic [DATA_WIDTH-1:0] in1;
    logic [DATA_WIDTH-1:0] in2;
    logic [DATA_WIDTH-1:0] in3;
    logic [DATA_WIDTH-1:0] in4;
    logic [DATA_WIDTH-1:0] max_input;
    logic                  softmax_enable;

    modport master (
        output in_valid, in_data, flush, softmax_done,
        input  in_ready, in1, in2, in3, in4, max_input, softmax_enable
    );

    modport slave (
        input  in_valid, in_data, flush, softmax_done,
        output in_ready, in1, in2, in3, in4, max_input, softmax_enable
    );
endinterface

// File: rtl/floating_point_softmax_input_collector.sv
// Collects groups of four floating-point words, tracks their maximum and
// hands the group to a softmax engine with a one-cycle start pulse, then
// waits for softmax_done before collecting the next group.
// Optional feature macro: SOFTMAX_NAN_FLAG_EN adds a registered nan_flag
// output, excludes NaN words from the maximum and reports a canonical qNaN
// when every word of a group is NaN.
module floating_point_softmax_input_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int E          = 8,
    parameter int M          = 23
) (
    input logic clk,
    input logic reset,
    floating_point_softmax_input_collector_if.slave bus
`ifdef SOFTMAX_NAN_FLAG_EN
    ,
    output logic nan_flag
`endif
);
    localparam int MAG_W = E + M;

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;

    logic [1:0]            state;
    logic [1:0]            idx;
    logic [DATA_WIDTH-1:0] run_max;
    logic [DATA_WIDTH-1:0] max_q;
    logic [DATA_WIDTH-1:0] slot_q [4];
    logic [DATA_WIDTH-1:0] word;
    logic                  first_word;
    logic [DATA_WIDTH-1:0] cand_max;
    logic [DATA_WIDTH-1:0] final_max;

`ifdef SOFTMAX_NAN_FLAG_EN
    localparam logic [DATA_WIDTH-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    logic have_max;
    logic nan_seen;
    logic word_nan;
    logic have_eff;
    logic nan_eff;
    logic cand_have;
`endif

    // Strict "a is larger than b" on sign-magnitude floats; both zeros compare equal.
    function automatic logic greater(input logic [DATA_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] b);
        logic [MAG_W-1:0] ma;
        logic [MAG_W-1:0] mb;
        logic             r;
        ma = a[MAG_W-1:0];
        mb = b[MAG_W-1:0];
        if (ma == '0 && mb == '0)
            r = 1'b0;
        else if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
            r = !a[DATA_WIDTH-1];
        else if (!a[DATA_WIDTH-1])
            r = (ma > mb);
        else
            r = (ma < mb);
        return r;
    endfunction

    // Running-max candidate including the word offered this cycle; ties keep the older word.
    always_comb begin
        word       = bus.in_data;
        first_word = (idx == 2'd0);
`ifdef SOFTMAX_NAN_FLAG_EN
        word_nan  = (word[DATA_WIDTH-2 -: E] == {E{1'b1}}) && (word[M-1:0] != '0);
        have_eff  = have_max && !first_word;
        nan_eff   = (nan_seen && !first_word) || word_nan;
        cand_max  = run_max;
        cand_have = have_eff;
        if (!word_nan && (!have_eff || greater(word, run_max))) begin
            cand_max  = word;
            cand_have = 1'b1;
        end
        final_max = cand_have ? cand_max : QNAN;
`else
        cand_max  = (first_word || greater(word, run_max)) ? word : run_max;
        final_max = cand_max;
`endif
    end

    // Group FSM, slot buffer and maximum tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= COLLECT;
            idx     <= 2'd0;
            run_max <= '0;
            max_q   <= '0;
            for (int i = 0; i < 4; i++) slot_q[i] <= '0;
`ifdef SOFTMAX_NAN_FLAG_EN
            have_max <= 1'b0;
            nan_seen <= 1'b0;
            nan_flag <= 1'b0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    if (bus.flush) begin
                        idx <= 2'd0;
                    end else if (bus.in_valid) begin
                        slot_q[idx] <= word;
                        run_max     <= cand_max;
                        idx         <= idx + 2'd1;
`ifdef SOFTMAX_NAN_FLAG_EN
                        have_max <= cand_have;
                        nan_seen <= nan_eff;
`endif
                        if (idx == 2'd3) begin
                            state <= ISSUE;
                            max_q <= final_max;
`ifdef SOFTMAX_NAN_FLAG_EN
                            nan_flag <= nan_eff;
`endif
                        end
                    end
                end
                ISSUE:   state <= WAIT;
                WAIT:    if (bus.softmax_done) state <= COLLECT;
                default: state <= COLLECT;
            endcase
        end
    end

    assign bus.in_ready       = (state == COLLECT);
    assign bus.softmax_enable = (state == ISSUE);
    assign bus.in1            = slot_q[0];
    assign bus.in2            = slot_q[1];
    assign bus.in3            = slot_q[2];
    assign bus.in4            = slot_q[3];
    assign bus.max_input      = max_q;
endmodule

// File: doc/floating_point_softmax_input_collector.md
FLOATING_POINT_SOFTMAX_INPUT_COLLECTOR -- requirements
Module: floating_point_softmax_input_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, float word width.
REQ-002 SHALL have parameter E, default 8, exponent width.
REQ-003 SHALL have parameter M, default 23, mantissa width; DATA_WIDTH = 1+E+M.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream word valid.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  upstream float word.
REQ-008 SHALL have port in_ready  output  1  collector accepts a word this cycle.
REQ-009 SHALL have port flush  input  1  discard the partial group.
REQ-010 SHALL have port softmax_done  input  1  downstream softmax finished the group.
REQ-011 SHALL have port in1, in2, in3, in4  output  DATA_WIDTH each  buffered words, in arrival order.
REQ-012 SHALL have port max_input  output  DATA_WIDTH  maximum of the four buffered words.
REQ-013 SHALL have port softmax_enable  output  1  one-cycle start pulse to the softmax.

Function
REQ-014 SHALL implement FSM states COLLECT, ISSUE and WAIT.
REQ-015 COLLECT: in_ready=1; a word is accepted when in_valid=1; it is written to slot idx (2-bit counter, 0..3); idx increments.
REQ-016 SHALL update a running max on every accepted word; the first word of a group loads it unconditionally.
REQ-017 Compare rule: for same-sign operands, positive larger magnitude wins and negative smaller magnitude wins; +x beats -y; +0 and -0 are equal.
REQ-018 On a tie the earlier word SHALL be kept.
REQ-019 Acceptance of the 4th word SHALL move COLLECT->ISSUE; idx wraps to 0.
REQ-020 ISSUE lasts one cycle: softmax_enable=1 and in_ready=0; the next state is WAIT.
REQ-021 softmax_enable SHALL be high exactly in the cycle after the 4th acceptance.
REQ-022 in1..in4 and max_input SHALL be valid from the ISSUE cycle and held stable until WAIT exits.
REQ-023 WAIT: in_ready=0; softmax_done=1 SHALL cause WAIT->COLLECT, so in_ready=1 from the following cycle.
REQ-024 softmax_done SHALL be ignored in COLLECT and ISSUE.
REQ-025 flush in COLLECT SHALL zero idx, discard the partial group and accept no word that cycle; in ISSUE or WAIT flush SHALL be ignored.
REQ-026 If flush and in_valid are both high, flush SHALL win.

Reset
REQ-027 reset SHALL force state=COLLECT, idx=0, running max=0, in1..in4=0, max_input=0, softmax_enable=0 and in_ready=1 after the edge.
REQ-028 reset mid-group or in WAIT SHALL abandon the group; no softmax_enable pulse SHALL follow.
REQ-029 reset SHALL dominate flush, in_valid and softmax_done.

Configuration
REQ-030 Macro SOFTMAX_NAN_FLAG_EN defined: the module SHALL have an extra output port nan_flag (1 bit), registered and reset to 0.
REQ-031 With SOFTMAX_NAN_FLAG_EN defined: a NaN is exponent all ones with a nonzero mantissa.
REQ-032 With SOFTMAX_NAN_FLAG_EN defined: NaN words SHALL be excluded from the max.
REQ-033 With SOFTMAX_NAN_FLAG_EN defined: if all four words are NaN, max_input SHALL be the canonical qNaN (sign 0, exponent all ones, mantissa MSB 1, other bits 0; 7FC00000 for the defaults).
REQ-034 With SOFTMAX_NAN_FLAG_EN defined: nan_flag SHALL be valid with softmax_enable and held through WAIT, set if any group word was NaN.
REQ-035 Macro SOFTMAX_NAN_FLAG_EN undefined: there SHALL be no nan_flag port, and NaNs SHALL be compared under the REQ-017 rule as ordinary bit patterns.

Verification
REQ-036 Words 3F800000, 40000000, C0400000, 3F000000 on consecutive cycles -> max_input=40000000 and in1..in4 in that order; softmax_enable for one cycle, one cycle after the 4th word.
REQ-037 Words BF800000, C0000000, BF000000, C0800000 -> max_input=BF000000.
REQ-038 Words 80000000, 00000000, BF800000, C0000000 -> max_input=80000000 (tie keeps the first word).
REQ-039 Two words, then flush, then 4 new words 3F800000 x4 -> one pulse only; max_input=3F800000; the pre-flush words do not appear.
REQ-040 in_valid held high after a group -> in_ready=0 through ISSUE and WAIT.
REQ-041 softmax_done pulsed 3 cycles after ISSUE -> in_ready=1 on the next cycle and the next group is collected correctly.
REQ-042 With SOFTMAX_NAN_FLAG_EN, words 7FC00001, 3F800000, BF800000, 7F800001 -> max_input=3F800000 and nan_flag=1.
REQ-043 reset asserted in WAIT -> in_ready=1 and all outputs 0 next cycle.
